// File: rtl/monostable_multi.sv
// monostable_multi: N_CH independent edge-triggered one-shot pulse generators
// sharing one programmable pulse length. Each channel has a two-state FSM with
// a down-counter. A sticky missed flag records edges dropped while a channel
// is busy.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | pulse low; an accepted edge loads cnt = L-1 and goes ACTIVE
//   ACTIVE | pulse high; cnt counts down, returns to IDLE after cnt == 0
module monostable_multi #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  parameter int RETRIG = 0
) (
  input  logic             reloj,
  input  logic             resetM,
  input  logic [N_CH-1:0]  trigger,
  input  logic             enable,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic             clr_missed,
  output logic [N_CH-1:0]  pulse,
  output logic [N_CH-1:0]  missed,
  output logic             any_pulse
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           st_q [N_CH];
  state_t           st_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  trig_q;
  logic [N_CH-1:0]  edge_ok;
  logic [N_CH-1:0]  miss_set;
  logic [N_CH-1:0]  pulse_d;
  logic [N_CH-1:0]  missed_d;
  logic             any_d;
  logic [CNT_W-1:0] len_m1;

  // A zero pulse_len is treated as one cycle, so the reload value saturates at 0.
  assign len_m1 = (pulse_len == '0) ? '0 : pulse_len - CNT_W'(1);

  // Only rising edges seen while enabled are acted on, either accepted or flagged.
  assign edge_ok = trigger & ~trig_q & {N_CH{enable}};

  // State register: per-channel FSM, counters, trigger history and registered outputs.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
      trig_q    <= '1;
      pulse     <= '0;
      missed    <= '0;
      any_pulse <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      trig_q    <= trigger;
      pulse     <= pulse_d;
      missed    <= missed_d;
      any_pulse <= any_d;
    end
  end

  // Next-state logic: start, count down, reload on retrigger, or drop the edge.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_q[i];
      miss_set[i] = 1'b0;
      case (st_q[i])
        IDLE: begin
          if (edge_ok[i]) begin
            st_d[i]  = ACTIVE;
            cnt_d[i] = len_m1;
          end
        end
        ACTIVE: begin
          if (edge_ok[i] && (RETRIG != 0)) begin
            cnt_d[i] = len_m1;
          end else begin
            miss_set[i] = edge_ok[i];
            if (cnt_q[i] == '0) begin
              st_d[i] = IDLE;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Output logic: pulse follows the next state so the registered pulse tracks
  // ACTIVE exactly; a missed-set wins over a simultaneous clear.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      pulse_d[i] = (st_d[i] == ACTIVE);
    end
    missed_d = (missed & ~{N_CH{clr_missed}}) | miss_set;
    any_d    = |pulse_d;
  end

endmodule

// File: tb/tb_monostable_multi.sv
// Bench for monostable_multi: one instance with RETRIG=0 and one with RETRIG=1
// share the same stimulus. Each cycle the expected outputs of both instances
// are pushed to a queue, and they are popped and compared at the falling edge.
module tb_monostable_multi;

  logic       clk;
  logic       rst;
  logic [3:0] trigger;
  logic       enable;
  logic [7:0] pulse_len;
  logic       clr_missed;
  logic [3:0] pulse0, missed0, pulse1, missed1;
  logic       any0, any1;

  int vectors;
  int miscompares;

  typedef struct {
    logic [17:0] v;
  } exp_t;
  exp_t sb[$];

  monostable_multi #(.N_CH(4), .CNT_W(8), .RETRIG(0)) dut0 (
    .reloj(clk), .resetM(rst), .trigger(trigger), .enable(enable),
    .pulse_len(pulse_len), .clr_missed(clr_missed),
    .pulse(pulse0), .missed(missed0), .any_pulse(any0)
  );

  monostable_multi #(.N_CH(4), .CNT_W(8), .RETRIG(1)) dut1 (
    .reloj(clk), .resetM(rst), .trigger(trigger), .enable(enable),
    .pulse_len(pulse_len), .clr_missed(clr_missed),
    .pulse(pulse1), .missed(missed1), .any_pulse(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic [3:0] p0, input logic [3:0] m0,
                                     input logic [3:0] p1, input logic [3:0] m1);
    return {p0, |p0, m0, p1, |p1, m1};
  endfunction

  // Apply one cycle of inputs just after the rising edge.
  task automatic drive(input logic [3:0] t, input logic en, input logic [7:0] len,
                       input logic clr, input logic r);
    @(posedge clk);
    #1;
    trigger    = t;
    enable     = en;
    pulse_len  = len;
    clr_missed = clr;
    rst        = r;
  endtask

  task automatic test_reset;
    exp_t e;
    logic [17:0] act;
    for (int c = 0; c < 8; c++) begin
      drive((c < 6) ? 4'b1111 : 4'b0000, 1'b1, 8'd3, 1'b0, (c < 2));
      e.v = mk(4'b0, 4'b0, 4'b0, 4'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      act = {pulse0, any0, missed0, pulse1, any1, missed1};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h want %h", c, act, e.v);
      end
    end
  endtask

  task automatic test_basic;
    exp_t e;
    logic [17:0] act;
    logic [3:0] p;
    for (int c = 0; c < 8; c++) begin
      drive((c == 0) ? 4'b0001 : 4'b0000, 1'b1, (c >= 2) ? 8'd20 : 8'd5, 1'b0, 1'b0);
      p = (c >= 1 && c <= 5) ? 4'b0001 : 4'b0000;
      e.v = mk(p, 4'b0, p, 4'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      act = {pulse0, any0, missed0, pulse1, any1, missed1};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL basic c%0d: got %h want %h", c, act, e.v);
      end
    end
  endtask

  task automatic test_zero_len;
    exp_t e;
    logic [17:0] act;
    logic [3:0] p;
    for (int c = 0; c < 4; c++) begin
      drive((c == 0) ? 4'b0100 : 4'b0000, 1'b1, 8'd0, 1'b0, 1'b0);
      p = (c == 1) ? 4'b0100 : 4'b0000;
      e.v = mk(p, 4'b0, p, 4'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      act = {pulse0, any0, missed0, pulse1, any1, missed1};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL zero_len c%0d: got %h want %h", c, act, e.v);
      end
    end
  endtask

  task automatic test_dropped_and_retrig;
    exp_t e;
    logic [17:0] act;
    logic [3:0] p0, m0, p1;
    for (int c = 0; c < 10; c++) begin
      drive((c == 0 || c == 3) ? 4'b0010 : 4'b0000, 1'b1, 8'd5, (c == 6), 1'b0);
      p0 = (c >= 1 && c <= 5) ? 4'b0010 : 4'b0000;
      m0 = (c >= 4 && c <= 6) ? 4'b0010 : 4'b0000;
      p1 = (c >= 1 && c <= 8) ? 4'b0010 : 4'b0000;
      e.v = mk(p0, m0, p1, 4'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      act = {pulse0, any0, missed0, pulse1, any1, missed1};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL dropped_retrig c%0d: got %h want %h", c, act, e.v);
      end
    end
  endtask

  // Edge lands in the cnt==0 cycle together with clr_missed.
  task automatic test_set_wins;
    exp_t e;
    logic [17:0] act;
    logic [3:0] p0, m0, p1;
    for (int c = 0; c < 7; c++) begin
      drive((c == 0 || c == 2) ? 4'b1000 : 4'b0000, 1'b1, 8'd2,
            (c == 2 || c == 5), 1'b0);
      p0 = (c >= 1 && c <= 2) ? 4'b1000 : 4'b0000;
      m0 = (c >= 3 && c <= 5) ? 4'b1000 : 4'b0000;
      p1 = (c >= 1 && c <= 4) ? 4'b1000 : 4'b0000;
      e.v = mk(p0, m0, p1, 4'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      act = {pulse0, any0, missed0, pulse1, any1, missed1};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL set_wins c%0d: got %h want %h", c, act, e.v);
      end
    end
  endtask

  task automatic test_enable;
    exp_t e;
    logic [17:0] act;
    logic [3:0] p;
    for (int c = 0; c < 7; c++) begin
      drive((c == 0 || c == 2) ? 4'b1001 : 4'b0000, (c >= 2), 8'd3, 1'b0, 1'b0);
      p = (c >= 3 && c <= 5) ? 4'b1001 : 4'b0000;
      e.v = mk(p, 4'b0, p, 4'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      act = {pulse0, any0, missed0, pulse1, any1, missed1};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL enable c%0d: got %h want %h", c, act, e.v);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic [17:0] act;
    logic [3:0] p;
    for (int c = 0; c < 9; c++) begin
      drive((c == 0) ? 4'b0001 : 4'b0000, 1'b1, 8'd10, 1'b0, (c == 5));
      p = (c >= 1 && c <= 5) ? 4'b0001 : 4'b0000;
      e.v = mk(p, 4'b0, p, 4'b0);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      act = {pulse0, any0, missed0, pulse1, any1, missed1};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL reset_mid c%0d: got %h want %h", c, act, e.v);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    trigger     = 4'b1111;
    enable      = 1'b1;
    pulse_len   = 8'd3;
    clr_missed  = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_dropped_and_retrig();
    test_set_wins();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/monostable_multi.md
MONOSTABLE_MULTI -- requirements
Module: monostable_multi

Interface
REQ-001 The module SHALL have parameter N_CH, default 4, which sets the number of independent trigger/pulse channels (1..16).
REQ-002 The module SHALL have parameter CNT_W, default 8, which sets the width of the pulse-length counter and the pulse_len input.
REQ-003 The module SHALL have parameter RETRIG, default 0: 0 means a channel ignores edges while its pulse is active; 1 means such an edge reloads the counter.
REQ-004 The module SHALL have port reloj, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port resetM, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port trigger, input, N_CH bits: one level trigger per channel, already synchronous to reloj.
REQ-007 The module SHALL have port enable, input, 1 bit: when high, new trigger edges are accepted.
REQ-008 The module SHALL have port pulse_len, input, CNT_W bits: the pulse length in reloj cycles, shared by all channels.
REQ-009 The module SHALL have port clr_missed, input, 1 bit: clears all missed flags.
REQ-010 The module SHALL have port pulse, output, N_CH bits: the per-channel one-shot output, registered.
REQ-011 The module SHALL have port missed, output, N_CH bits: sticky per-channel flag, set when an edge is dropped.
REQ-012 The module SHALL have port any_pulse, output, 1 bit: the OR of all pulse bits, registered and cycle-aligned with pulse.

Function
REQ-013 Each channel SHALL hold a registered copy trig_q of its trigger; an edge on channel i SHALL be detected when trigger[i]=1 and trig_q[i]=0.
REQ-014 Each channel SHALL run a 2-state FSM, IDLE and ACTIVE; pulse[i] SHALL be 1 exactly while the channel is in ACTIVE.
REQ-015 An edge accepted in IDLE at cycle k SHALL move the channel to ACTIVE and load cnt = L-1, where L = max(pulse_len,1) sampled at cycle k; pulse[i] SHALL be high during cycles k+1 through k+L.
REQ-016 In ACTIVE, cnt SHALL decrement by 1 each cycle; when cnt=0 and no reload occurs, the channel SHALL return to IDLE on the next cycle.
REQ-017 Changes to pulse_len while a channel is ACTIVE SHALL NOT affect that pulse, except on a retrigger reload.
REQ-018 With RETRIG=1, an edge accepted in ACTIVE, including in the cycle where cnt=0, SHALL reload cnt = L-1 using the current pulse_len; pulse SHALL stay high with no low gap.
REQ-019 With RETRIG=0, an edge while ACTIVE, including in the cycle where cnt=0, SHALL be ignored and SHALL set missed[i] on the next cycle.
REQ-020 With RETRIG=1, missed SHALL never be set.
REQ-021 While enable=0, edges SHALL be neither accepted nor flagged as missed; trig_q SHALL still update; pulses already ACTIVE SHALL complete normally.
REQ-022 If clr_missed and a missed-set event occur in the same cycle, missed SHALL end up set (set wins).
REQ-023 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each start a pulse in the same cycle.
REQ-024 any_pulse SHALL equal the OR of the pulse bits in the same cycle.

Reset
REQ-025 While resetM=1 at a rising edge of reloj: pulse, any_pulse, missed and cnt SHALL clear to 0, all FSMs SHALL go to IDLE, and trig_q SHALL be set to all ones.
REQ-026 Because trig_q resets to all ones, a trigger already high at reset release SHALL NOT fire until it goes low and then high again.
REQ-027 Asserting resetM during an ACTIVE pulse SHALL force pulse low on the next cycle, with no resumption after reset.

Verification (N_CH=4, CNT_W=8)
REQ-028 The bench SHALL cover a basic pulse: RETRIG=0, pulse_len=5, trigger[0] rises at cycle k -> pulse[0] and any_pulse are high in cycles k+1 to k+5 and low at k+6; the other channels stay 0.
REQ-029 The bench SHALL cover a zero length: pulse_len=0 with an edge on channel 2 -> pulse[2] is high for exactly 1 cycle.
REQ-030 The bench SHALL cover a dropped edge: RETRIG=0, len 5, trigger[1] edges at k and k+3 -> the pulse ends after k+5, missed[1]=1 from k+4, and a clr_missed pulse clears it on the following cycle.
REQ-031 The bench SHALL cover retriggering: RETRIG=1 with the same stimulus -> pulse[1] is high from k+1 to k+8 continuously, and missed stays 0.
REQ-032 The bench SHALL cover enable gating: enable=0, edges on channels 0 and 3 -> no pulses; then enable=1 and new edges on channels 0 and 3 -> both pulses start in the same cycle.
REQ-033 The bench SHALL cover reset behaviour: trigger=4'b1111 held through reset release -> no pulses; resetM raised at the mid-point of a 10-cycle pulse -> pulse is 0 on the next cycle.
